uart_wb_bridge: RTL and testbench

UART_WB_BRIDGE -- requirements
Module: uart_wb_bridge

---
 rtl/uart_wb_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_uart_wb_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_bridge.sv
// UART command bridge driving a single-beat Wishbone master.
// Optional ACK timeout: define UART_WB_TIMEOUT_EN.
module uart_wb_bridge #(
  parameter logic [14:0] BPS_CNT_MAX = 15'd868,
  parameter logic [7:0]  TIMEOUT_MAX = 8'd255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_tx,
  output logic [2:0] Master_WB_ADRo,
  output logic [7:0] Master_WB_DATo,
  input  logic [7:0] Master_WB_DATi,
  output logic       Master_WB_WEo,
  output logic       Master_WB_CYCo,
  output logic       Master_WB_STBo,
  input  logic       Master_WB_ACKi,
  output logic       o_busy,
  output logic       o_frame_err
);

  localparam logic [14:0] BIT_END = BPS_CNT_MAX - 15'd1;
  localparam logic [14:0] BIT_MID = BPS_CNT_MAX >> 1;
  localparam logic [7:0]  TMO_END = TIMEOUT_MAX - 8'd1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    IDLE,
    GET_DATA,
    BUS,
    SEND
  } state_t;

  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  rx_state_t   rx_state;
  logic [14:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;
  logic        rx_stop_hit;
  logic        rx_done;
  logic        rx_ferr;

  state_t      state;
  logic [14:0] tx_cnt;
  logic [3:0]  tx_idx;
  logic [7:0]  resp;
  logic [7:0]  tmo_cnt;
  logic        tmo_hit;

  // Receiver: rx_prev is an edge register behind the 2-flop synchroniser
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1   <= i_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      unique case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == BIT_MID) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 15'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_idx   <= rx_idx + 3'd1;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 15'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 15'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_stop_hit = (rx_state == RX_STOP) && (rx_cnt == BIT_END);
  assign rx_done     = rx_stop_hit && rx_s2;
  assign rx_ferr     = rx_stop_hit && !rx_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_frame_err <= 1'b0;
    else          o_frame_err <= rx_ferr;
  end

  // Counts cycles spent with STB up; saturates so it never wraps
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)             tmo_cnt <= '0;
    else if (state != BUS)    tmo_cnt <= '0;
    else if (tmo_cnt != TMO_END) tmo_cnt <= tmo_cnt + 8'd1;
  end

`ifdef UART_WB_TIMEOUT_EN
  assign tmo_hit = (tmo_cnt == TMO_END);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      o_tx           <= 1'b1;
      o_busy         <= 1'b0;
      Master_WB_ADRo <= '0;
      Master_WB_DATo <= '0;
      Master_WB_WEo  <= 1'b0;
      Master_WB_CYCo <= 1'b0;
      Master_WB_STBo <= 1'b0;
      tx_cnt         <= '0;
      tx_idx         <= '0;
      resp           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_done) begin
            Master_WB_ADRo <= rx_shift[2:0];
            Master_WB_WEo  <= rx_shift[7];
            o_busy         <= 1'b1;
            if (rx_shift[7]) begin
              state <= GET_DATA;
            end else begin
              state          <= BUS;
              Master_WB_CYCo <= 1'b1;
              Master_WB_STBo <= 1'b1;
            end
          end
        end
        GET_DATA: begin
          if (rx_done) begin
            state          <= BUS;
            Master_WB_DATo <= rx_shift;
            Master_WB_CYCo <= 1'b1;
            Master_WB_STBo <= 1'b1;
          end else if (rx_ferr) begin
            state         <= IDLE;
            o_busy        <= 1'b0;
            Master_WB_WEo <= 1'b0;
          end
        end
        BUS: begin
          if (Master_WB_ACKi || tmo_hit) begin
            state          <= SEND;
            Master_WB_CYCo <= 1'b0;
            Master_WB_STBo <= 1'b0;
            Master_WB_WEo  <= 1'b0;
            o_tx           <= 1'b0;
            tx_cnt         <= '0;
            tx_idx         <= '0;
            if (!Master_WB_ACKi)    resp <= 8'hEE;
            else if (Master_WB_WEo) resp <= 8'h55;
            else                    resp <= Master_WB_DATi;
          end
        end
        SEND: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            tx_idx <= tx_idx + 4'd1;
            unique case (1'b1)
              tx_idx == 4'd9: begin
                state  <= IDLE;
                o_busy <= 1'b0;
                o_tx   <= 1'b1;
              end
              tx_idx == 4'd8: o_tx <= 1'b1;
              default:        o_tx <= resp[tx_idx[2:0]];
            endcase
          end else begin
            tx_cnt <= tx_cnt + 15'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge with an 8-clock bit period.
// Expectations for the ACK timeout follow UART_WB_TIMEOUT_EN.
module tb_uart_wb_bridge;

  localparam int BPS = 8;
  localparam int TMO = 255;

  typedef struct {
    logic [2:0] adr;
    logic [7:0] dat;
    logic       we;
    int         len;
  } wb_exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       tx;
  logic [2:0] adr;
  logic [7:0] dat;
  logic [7:0] rdata;
  logic       we;
  logic       cyc;
  logic       stb;
  logic       ack;
  logic       busy;
  logic       ferr;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ferr_cnt = 0;
  int ack_delay = 1;

  wb_exp_t    wb_q[$];
  logic [7:0] tx_q[$];

  uart_wb_bridge #(
    .BPS_CNT_MAX(15'd8),
    .TIMEOUT_MAX(8'd255)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rx          (rx),
    .o_tx          (tx),
    .Master_WB_ADRo(adr),
    .Master_WB_DATo(dat),
    .Master_WB_DATi(rdata),
    .Master_WB_WEo (we),
    .Master_WB_CYCo(cyc),
    .Master_WB_STBo(stb),
    .Master_WB_ACKi(ack),
    .o_busy        (busy),
    .o_frame_err   (ferr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Slave: ACK raised ack_delay cycles after STB rises (negative = never)
  int scnt = 0;
  always @(negedge clk) begin
    if (stb) begin
      ack = (ack_delay >= 0) && (scnt == ack_delay);
      scnt++;
    end else begin
      ack = 1'b0;
      scnt = 0;
    end
  end

  always @(negedge clk) if (ferr) ferr_cnt++;

  // Wishbone monitor
  logic       stb_d = 1'b0;
  logic [11:0] hold;
  logic       unstable;
  int         run = 0;
  wb_exp_t    cur;
  always @(negedge clk) begin
    if (stb && !stb_d) begin
      check("wb_pending", wb_q.size() != 0, 1);
      if (wb_q.size() != 0) begin
        cur = wb_q.pop_front();
        check("wb_adr", adr, cur.adr);
        check("wb_we", we, cur.we);
        check("wb_cyc", cyc, 1);
        if (cur.we) check("wb_dat", dat, cur.dat);
      end else begin
        cur.len = 0;
      end
      hold = {adr, dat, we};
      unstable = 1'b0;
      run = 1;
    end else if (stb) begin
      run++;
      if ({adr, dat, we} !== hold) unstable = 1'b1;
    end
    if (!stb && stb_d && rst_n) begin
      if (cur.len != 0) check("wb_len", run, cur.len);
      check("wb_stable", unstable, 0);
      check("wb_drop", {cyc, we}, 0);
    end
    stb_d = stb;
  end

  // Serial response monitor; frames cut by reset are dropped
  always begin
    logic [7:0] b;
    logic       cut;
    logic       stop;
    @(negedge clk);
    if (rst_n && tx === 1'b0) begin
      cut = 1'b0;
      repeat (BPS / 2) @(negedge clk);
      cut |= !rst_n || tx !== 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (BPS) @(negedge clk);
        b[i] = tx;
        cut |= !rst_n;
      end
      repeat (BPS) @(negedge clk);
      stop = tx;
      cut |= !rst_n;
      if (!cut) begin
        check("tx_pending", tx_q.size() != 0, 1);
        if (tx_q.size() != 0) check("tx_byte", b, tx_q.pop_front());
        check("tx_stop", stop, 1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BPS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BPS) @(negedge clk);
    end
    rx = stop;
    repeat (BPS) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check("done", busy, 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_tx_low(input int max);
    int n = 0;
    while (tx !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("tx_start", tx, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0;
    int n;
    rst_n = 1'b0;
    rx = 1'b1;
    ack = 1'b0;
    rdata = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_wb", {cyc, stb, we}, 0);
    check("rst_adr_dat", {adr, dat}, 0);
    check("rst_busy_ferr", {busy, ferr}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write 0xA5 to address 3
    ack_delay = 1;
    wb_q.push_back('{3'd3, 8'hA5, 1'b1, 2});
    tx_q.push_back(8'h55);
    send_byte(8'h83, 1'b1);
    check("busy_get_data", busy, 1);
    send_byte(8'hA5, 1'b1);
    wait_done(300);

    // Read address 4, slow ACK, busy drops 80 clocks after start bit
    ack_delay = 5;
    rdata = 8'h3C;
    wb_q.push_back('{3'd4, 8'h00, 1'b0, 6});
    tx_q.push_back(8'h3C);
    send_byte(8'h04, 1'b1);
    wait_tx_low(100);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_len", n, 10 * BPS);
    repeat (10) @(negedge clk);

    // Bad stop bit on a command byte
    f0 = ferr_cnt;
    send_byte(8'h81, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_cmd", ferr_cnt, f0 + 1);
    check("ferr_cmd_busy", busy, 0);

    // Bad stop bit on the data byte aborts the write
    send_byte(8'h83, 1'b1);
    check("busy_get_data2", busy, 1);
    send_byte(8'hA5, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_data", ferr_cnt, f0 + 2);
    check("ferr_data_busy", busy, 0);

    // No ACK; a byte arriving during BUS must be ignored
    ack_delay = -1;
    rdata = 8'h99;
`ifdef UART_WB_TIMEOUT_EN
    wb_q.push_back('{3'd2, 8'h00, 1'b0, TMO});
    tx_q.push_back(8'hEE);
`else
    wb_q.push_back('{3'd2, 8'h00, 1'b0, 0});
`endif
    send_byte(8'h02, 1'b1);
    send_byte(8'h85, 1'b1);
`ifdef UART_WB_TIMEOUT_EN
    wait_done(600);
`else
    repeat (300) @(negedge clk);
    check("stb_stuck", {cyc, stb}, 2'b11);
    check("busy_stuck", busy, 1);
`endif
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset in the middle of a response
    ack_delay = 1;
    rdata = 8'h77;
    wb_q.push_back('{3'd1, 8'h00, 1'b0, 2});
    send_byte(8'h01, 1'b1);
    wait_tx_low(100);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_cyc", {cyc, stb}, 0);
    check("mid_rst_busy", busy, 0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    rdata = 8'h9A;
    wb_q.push_back('{3'd1, 8'h00, 1'b0, 2});
    tx_q.push_back(8'h9A);
    send_byte(8'h01, 1'b1);
    wait_done(300);

    repeat (50) @(negedge clk);
    check("wb_q_empty", wb_q.size(), 0);
    check("tx_q_empty", tx_q.size(), 0);
    check("ferr_total", ferr_cnt, 2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
